// File: rtl/flit_credit_injector_pkg.sv
// rtl/flit_credit_injector_pkg.sv - shared widths, credit word type and flit field helper
package flit_credit_injector_pkg;

  localparam int DEF_FLIT_WIDTH = 32;
  localparam int DEF_NUM_VCS    = 2;
  localparam int DEF_VC_BITS    = 1;
  localparam int DEF_DEST_BITS  = 4;
  localparam int DEF_BUF_DEPTH  = 4;

  // Flit layout is {valid, tail, dest, vc, data}; vc sits directly above data.
  localparam int DEF_DATA_W = DEF_FLIT_WIDTH - 2 - DEF_DEST_BITS - DEF_VC_BITS;
  localparam int DEF_CNT_W  = $clog2(DEF_BUF_DEPTH + 1);

  typedef struct packed {
    logic                   valid;
    logic [DEF_VC_BITS-1:0] vc;
  } credit_t;

  function automatic logic [DEF_VC_BITS-1:0] flit_vc(input logic [DEF_FLIT_WIDTH-1:0] flit);
    return flit[DEF_DATA_W +: DEF_VC_BITS];
  endfunction

endpackage

// File: rtl/flit_skid_fifo2.sv
// rtl/flit_skid_fifo2.sv - two-entry ready/valid FIFO, ready driven from registered count only
module flit_skid_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign s_tready = (count != 2'd2);
  assign m_tvalid = (count != 2'd0);
  assign m_tdata  = mem[rd_ptr];
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s_tdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/flit_credit_injector.sv
// rtl/flit_credit_injector.sv - buffers serializer flits and injects them into a router port under per-VC credit control
module flit_credit_injector
  import flit_credit_injector_pkg::*;
#(
  parameter int FLIT_WIDTH = DEF_FLIT_WIDTH,
  parameter int NUM_VCS    = DEF_NUM_VCS,
  parameter int VC_BITS    = DEF_VC_BITS,
  parameter int DEST_BITS  = DEF_DEST_BITS,
  parameter int BUF_DEPTH  = DEF_BUF_DEPTH
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic                  in_flit_valid,
  output logic                  in_flit_ready,
  output logic [FLIT_WIDTH-1:0] put_flit,
  input  logic [VC_BITS:0]      credit_in,
  output logic                  credit_error,
  output logic                  drained
);

  localparam int DATA_W = FLIT_WIDTH - 2 - DEST_BITS - VC_BITS;
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

  logic [FLIT_WIDTH-1:0] head;
  logic                  head_valid;
  logic                  send;
  logic [VC_BITS-1:0]    head_vc;
  logic                  ret_valid;
  logic [VC_BITS-1:0]    ret_vc;
  logic [NUM_VCS-1:0]    inc;
  logic [NUM_VCS-1:0]    dec;
  logic                  all_full;
  logic [CNT_W-1:0]      credit [NUM_VCS];

  flit_skid_fifo2 #(.WIDTH(FLIT_WIDTH)) u_fifo (
    .clk      (CLK),
    .rst_n    (RST_N),
    .s_tdata  (in_flit),
    .s_tvalid (in_flit_valid),
    .s_tready (in_flit_ready),
    .m_tdata  (head),
    .m_tvalid (head_valid),
    .m_tready (send)
  );

  // Credits are checked from the registered counters only: a return never bypasses into this cycle's send.
  assign head_vc   = head[DATA_W +: VC_BITS];
  assign send      = head_valid && (credit[head_vc] != '0);
  assign ret_valid = credit_in[VC_BITS];
  assign ret_vc    = credit_in[VC_BITS-1:0];

  always_comb begin
    inc      = '0;
    dec      = '0;
    all_full = 1'b1;
    for (int v = 0; v < NUM_VCS; v++) begin
      inc[v] = ret_valid && (ret_vc == VC_BITS'(v));
      dec[v] = send && (head_vc == VC_BITS'(v));
      if (credit[v] != FULL) begin
        all_full = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      put_flit     <= '0;
      credit_error <= 1'b0;
      for (int v = 0; v < NUM_VCS; v++) begin
        credit[v] <= FULL;
      end
    end else begin
      put_flit <= send ? {1'b1, head[FLIT_WIDTH-2:0]} : '0;
      for (int v = 0; v < NUM_VCS; v++) begin
        if (inc[v] && !dec[v]) begin
          if (credit[v] == FULL) begin
            credit_error <= 1'b1;
          end else begin
            credit[v] <= credit[v] + CNT_W'(1);
          end
        end else if (dec[v] && !inc[v]) begin
          credit[v] <= credit[v] - CNT_W'(1);
        end
      end
    end
  end

  assign drained = !head_valid && !put_flit[FLIT_WIDTH-1] && all_full;

endmodule
